// File: rtl/smiley_game_pkg.sv
// Shared types and default constants for the smiley game controller.
// Build option SMILEY_CTRL_PAUSE_EN adds the PAUSE state to the encoding.
package smiley_game_pkg;

  localparam int DEF_MAX_LIVES     = 3;
  localparam int DEF_HIT_FRAMES    = 30;
  localparam int DEF_JUMP_COOLDOWN = 8;
  localparam int BLINK_BIT         = 2;

`ifdef SMILEY_CTRL_PAUSE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_HIT, S_RESPAWN, S_OVER, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_HIT, S_RESPAWN, S_OVER
  } state_t;
`endif

endpackage

// File: rtl/key_rise_detect.sv
// Rising-edge detector for a key level; the history bit resets high so a key
// held through reset does not produce an edge.
module key_rise_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_prev <= 1'b1;
    else         r_prev <= i_key;
  end

  assign o_rise = i_key & ~r_prev;

endmodule

// File: rtl/smiley_game_ctrl.sv
// Play-state controller in front of the smiley mover: lives, direction, jumps,
// frame gating and respawn. Define SMILEY_CTRL_PAUSE_EN to add the pause key.
module smiley_game_ctrl
  import smiley_game_pkg::*;
#(
  parameter  int MAX_LIVES     = DEF_MAX_LIVES,
  parameter  int HIT_FRAMES    = DEF_HIT_FRAMES,
  parameter  int JUMP_COOLDOWN = DEF_JUMP_COOLDOWN,
  parameter  int DIR_INIT      = 1,
  localparam int LW            = $clog2(MAX_LIVES + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_startOfFrame,
  input  logic          i_startGame,
  input  logic          i_dirKey,
  input  logic          i_jumpKey,
`ifdef SMILEY_CTRL_PAUSE_EN
  input  logic          i_pauseKey,
`endif
  input  logic          i_hitObstacle,
  input  logic          i_hitBonus,
  output logic          o_frameTick,
  output logic          o_X_direction,
  output logic          o_toggleY,
  output logic          o_respawn,
  output logic [LW-1:0] o_lives,
  output logic          o_gameOver,
  output logic          o_blink
);

  localparam int CW  = $clog2(JUMP_COOLDOWN + 1);
  localparam int HCW = ($clog2(HIT_FRAMES + 1) > BLINK_BIT + 1) ?
                       $clog2(HIT_FRAMES + 1) : BLINK_BIT + 1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [LW-1:0]    r_lives;
  logic             r_xDir;
  logic             r_toggleY;
  logic [CW-1:0]    r_cooldown;
  logic [HCW-1:0]   r_hitCnt;

  logic w_startRise, w_dirRise, w_jumpRise;
  logic w_inRun, w_start, w_keysOk, w_pauseEvt, w_bonusOk, w_jumpOk, w_hitDone;

  key_rise_detect u_startRise (.i_clk(i_clk), .i_reset(i_reset), .i_key(i_startGame), .o_rise(w_startRise));
  key_rise_detect u_dirRise   (.i_clk(i_clk), .i_reset(i_reset), .i_key(i_dirKey),    .o_rise(w_dirRise));
  key_rise_detect u_jumpRise  (.i_clk(i_clk), .i_reset(i_reset), .i_key(i_jumpKey),   .o_rise(w_jumpRise));

`ifdef SMILEY_CTRL_PAUSE_EN
  logic w_pauseRise;
  key_rise_detect u_pauseRise (.i_clk(i_clk), .i_reset(i_reset), .i_key(i_pauseKey), .o_rise(w_pauseRise));
  assign w_pauseEvt = w_inRun & ~i_hitObstacle & w_pauseRise;
`else
  assign w_pauseEvt = 1'b0;
`endif

  // A hit in RUN pre-empts every other RUN event; pause pre-empts the bonus.
  assign w_inRun   = (r_state == S_RUN);
  assign w_start   = ((r_state == S_IDLE) || (r_state == S_OVER)) && w_startRise;
  assign w_keysOk  = w_inRun & ~i_hitObstacle;
  assign w_bonusOk = w_keysOk & ~w_pauseEvt & i_hitBonus;
  assign w_jumpOk  = w_keysOk & w_jumpRise & (r_cooldown == '0);
  assign w_hitDone = (r_state == S_HIT) && i_startOfFrame &&
                     (r_hitCnt == HCW'(HIT_FRAMES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (w_startRise) w_stateNext = S_RESPAWN;
      S_RUN: begin
        if (i_hitObstacle)   w_stateNext = S_HIT;
        else if (w_pauseEvt) w_stateNext = state_t'(w_stateNext);
`ifdef SMILEY_CTRL_PAUSE_EN
        if (w_pauseEvt)      w_stateNext = S_PAUSE;
`endif
      end
      S_HIT:     if (w_hitDone) w_stateNext = (r_lives == '0) ? S_OVER : S_RESPAWN;
      S_RESPAWN: w_stateNext = S_RUN;
`ifdef SMILEY_CTRL_PAUSE_EN
      S_PAUSE:   if (w_pauseRise) w_stateNext = S_RUN;
`endif
      default:   w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    o_frameTick = i_startOfFrame && w_inRun;
    o_respawn   = (r_state == S_RESPAWN);
    o_gameOver  = (r_state == S_OVER);
    o_blink     = (r_state == S_HIT) && r_hitCnt[BLINK_BIT];
  end

  // Cooldown only ticks in RUN, so it stays frozen while paused or hit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lives    <= '0;
      r_xDir     <= 1'(DIR_INIT);
      r_toggleY  <= 1'b0;
      r_cooldown <= '0;
      r_hitCnt   <= '0;
    end else begin
      r_toggleY <= w_jumpOk;
      if (w_start) begin
        r_lives <= LW'(MAX_LIVES);
        r_xDir  <= 1'(DIR_INIT);
      end else if (w_inRun && i_hitObstacle) begin
        if (r_lives != '0) r_lives <= r_lives - 1'b1;
      end else if (w_bonusOk && (r_lives < LW'(MAX_LIVES))) begin
        r_lives <= r_lives + 1'b1;
      end
      if (w_keysOk && w_dirRise) r_xDir <= ~r_xDir;
      if (w_start)
        r_cooldown <= '0;
      else if (w_jumpOk)
        r_cooldown <= CW'(JUMP_COOLDOWN);
      else if (w_inRun && i_startOfFrame && (r_cooldown != '0))
        r_cooldown <= r_cooldown - 1'b1;
      if (w_inRun && i_hitObstacle)
        r_hitCnt <= '0;
      else if ((r_state == S_HIT) && i_startOfFrame)
        r_hitCnt <= r_hitCnt + 1'b1;
    end
  end

  assign o_X_direction = r_xDir;
  assign o_toggleY     = r_toggleY;
  assign o_lives       = r_lives;

endmodule

// File: tb/tb_smiley_game_ctrl.sv
// Directed self-checking bench for smiley_game_ctrl; the pause scenario is
// only built when SMILEY_CTRL_PAUSE_EN is defined.
module tb_smiley_game_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset, i_startOfFrame, i_startGame, i_dirKey, i_jumpKey;
  logic       i_pauseKey, i_hitObstacle, i_hitBonus;
  logic       o_frameTick, o_X_direction, o_toggleY, o_respawn, o_gameOver, o_blink;
  logic [1:0] o_lives;
  int         nChecks = 0;
  int         nErrors = 0;

  smiley_game_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_startOfFrame(i_startOfFrame),
    .i_startGame(i_startGame), .i_dirKey(i_dirKey), .i_jumpKey(i_jumpKey),
`ifdef SMILEY_CTRL_PAUSE_EN
    .i_pauseKey(i_pauseKey),
`endif
    .i_hitObstacle(i_hitObstacle), .i_hitBonus(i_hitBonus),
    .o_frameTick(o_frameTick), .o_X_direction(o_X_direction), .o_toggleY(o_toggleY),
    .o_respawn(o_respawn), .o_lives(o_lives), .o_gameOver(o_gameOver), .o_blink(o_blink)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic runFrames(input int n);
    repeat (n) begin
      i_startOfFrame = 1'b1; tick();
      i_startOfFrame = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_startGame = 1'b1; i_dirKey = 1'b1; i_jumpKey = 1'b0;
    i_pauseKey = 1'b0; i_hitObstacle = 1'b0; i_hitBonus = 1'b0; i_startOfFrame = 1'b0;
    repeat (3) tick();
    i_startOfFrame = 1'b1; #1;
    nChecks++; if (o_lives !== 2'd0) begin nErrors++; $display("[TB] FAIL reset_lives got %0d want 0", o_lives); end
    nChecks++; if (o_X_direction !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_dir got %0b want 1", o_X_direction); end
    nChecks++; if ({o_toggleY, o_respawn, o_gameOver, o_blink, o_frameTick} !== 5'b0) begin nErrors++; $display("[TB] FAIL reset_pulses got %b want 00000", {o_toggleY, o_respawn, o_gameOver, o_blink, o_frameTick}); end
    i_startOfFrame = 1'b0;
    tick();
    i_reset = 1'b0;
    tick(); tick();
    nChecks++; if ({o_respawn, o_lives} !== 3'b000) begin nErrors++; $display("[TB] FAIL held_start_no_edge got %b want 000", {o_respawn, o_lives}); end
  endtask

  task automatic test_start();
    i_startGame = 1'b0; tick();
    i_startGame = 1'b1; tick();
    nChecks++; if (o_respawn !== 1'b1) begin nErrors++; $display("[TB] FAIL start_respawn got %0b want 1", o_respawn); end
    nChecks++; if (o_lives !== 2'd3) begin nErrors++; $display("[TB] FAIL start_lives got %0d want 3", o_lives); end
    i_startGame = 1'b0; tick();
    nChecks++; if (o_respawn !== 1'b0) begin nErrors++; $display("[TB] FAIL respawn_one_clock got %0b want 0", o_respawn); end
    nChecks++; if (o_X_direction !== 1'b1) begin nErrors++; $display("[TB] FAIL held_dir_no_edge got %0b want 1", o_X_direction); end
    i_startOfFrame = 1'b1; #1;
    nChecks++; if (o_frameTick !== 1'b1) begin nErrors++; $display("[TB] FAIL run_frametick got %0b want 1", o_frameTick); end
    tick(); i_startOfFrame = 1'b0; #1;
    nChecks++; if (o_frameTick !== 1'b0) begin nErrors++; $display("[TB] FAIL run_frametick_low got %0b want 0", o_frameTick); end
  endtask

  task automatic test_dir();
    i_dirKey = 1'b0; tick();
    i_dirKey = 1'b1; tick();
    nChecks++; if (o_X_direction !== 1'b0) begin nErrors++; $display("[TB] FAIL dir_flip1 got %0b want 0", o_X_direction); end
    i_dirKey = 1'b0; tick();
    i_dirKey = 1'b1; tick();
    nChecks++; if (o_X_direction !== 1'b1) begin nErrors++; $display("[TB] FAIL dir_flip2 got %0b want 1", o_X_direction); end
    i_dirKey = 1'b0; tick();
  endtask

  task automatic test_jump();
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b1) begin nErrors++; $display("[TB] FAIL jump_f0 got %0b want 1", o_toggleY); end
    i_jumpKey = 1'b0; tick();
    nChecks++; if (o_toggleY !== 1'b0) begin nErrors++; $display("[TB] FAIL jump_pulse_width got %0b want 0", o_toggleY); end
    runFrames(5);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b0) begin nErrors++; $display("[TB] FAIL jump_f5_dropped got %0b want 0", o_toggleY); end
    i_jumpKey = 1'b0; tick();
    runFrames(4);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b1) begin nErrors++; $display("[TB] FAIL jump_f9 got %0b want 1", o_toggleY); end
    i_jumpKey = 1'b0; tick();
    runFrames(7);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b0) begin nErrors++; $display("[TB] FAIL jump_cd1_dropped got %0b want 0", o_toggleY); end
    i_jumpKey = 1'b0; tick();
    runFrames(1);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b1) begin nErrors++; $display("[TB] FAIL jump_cd0 got %0b want 1", o_toggleY); end
    i_jumpKey = 1'b0; tick();
  endtask

  task automatic test_bonus_sat();
    i_hitBonus = 1'b1; tick();
    i_hitBonus = 1'b0; tick();
    nChecks++; if (o_lives !== 2'd3) begin nErrors++; $display("[TB] FAIL bonus_saturate got %0d want 3", o_lives); end
  endtask

  task automatic test_hit();
    i_hitObstacle = 1'b1; i_hitBonus = 1'b1; i_startOfFrame = 1'b1; #1;
    nChecks++; if (o_frameTick !== 1'b1) begin nErrors++; $display("[TB] FAIL tick_on_hit_clock got %0b want 1", o_frameTick); end
    tick();
    i_hitObstacle = 1'b0; i_hitBonus = 1'b0; i_startOfFrame = 1'b0;
    nChecks++; if (o_lives !== 2'd2) begin nErrors++; $display("[TB] FAIL hit_lives got %0d want 2", o_lives); end
    for (int f = 0; f < 30; f++) begin
      i_startOfFrame = 1'b1; #1;
      nChecks++; if (o_frameTick !== 1'b0) begin nErrors++; $display("[TB] FAIL hit_no_tick frame %0d got %0b want 0", f, o_frameTick); end
      nChecks++; if (o_blink !== ((f >> 2) & 1)) begin nErrors++; $display("[TB] FAIL hit_blink frame %0d got %0b want %0d", f, o_blink, (f >> 2) & 1); end
      tick();
      i_startOfFrame = 1'b0;
      if (f < 29) tick();
    end
    nChecks++; if (o_respawn !== 1'b1) begin nErrors++; $display("[TB] FAIL hit_end_respawn got %0b want 1", o_respawn); end
    tick();
    nChecks++; if (o_respawn !== 1'b0) begin nErrors++; $display("[TB] FAIL hit_respawn_width got %0b want 0", o_respawn); end
  endtask

  task automatic test_game_over();
    i_hitObstacle = 1'b1; tick(); i_hitObstacle = 1'b0;
    nChecks++; if (o_lives !== 2'd1) begin nErrors++; $display("[TB] FAIL hit2_lives got %0d want 1", o_lives); end
    runFrames(29); i_startOfFrame = 1'b1; tick(); i_startOfFrame = 1'b0;
    nChecks++; if (o_respawn !== 1'b1) begin nErrors++; $display("[TB] FAIL hit2_respawn got %0b want 1", o_respawn); end
    tick();
    i_hitBonus = 1'b1; i_dirKey = 1'b1; tick();
    i_hitBonus = 1'b0; i_dirKey = 1'b0;
    nChecks++; if (o_lives !== 2'd2) begin nErrors++; $display("[TB] FAIL bonus_inc got %0d want 2", o_lives); end
    nChecks++; if (o_X_direction !== 1'b0) begin nErrors++; $display("[TB] FAIL dir_with_bonus got %0b want 0", o_X_direction); end
    tick();
    i_hitObstacle = 1'b1; tick(); i_hitObstacle = 1'b0;
    runFrames(29); i_startOfFrame = 1'b1; tick(); i_startOfFrame = 1'b0;
    tick();
    i_hitObstacle = 1'b1; tick(); i_hitObstacle = 1'b0;
    nChecks++; if (o_lives !== 2'd0) begin nErrors++; $display("[TB] FAIL hit_last_lives got %0d want 0", o_lives); end
    runFrames(29); i_startOfFrame = 1'b1; tick(); i_startOfFrame = 1'b0;
    nChecks++; if ({o_gameOver, o_respawn} !== 2'b10) begin nErrors++; $display("[TB] FAIL over_entry got %b want 10", {o_gameOver, o_respawn}); end
    i_hitBonus = 1'b1; tick(); i_hitBonus = 1'b0; tick();
    nChecks++; if ({o_gameOver, o_respawn, o_lives} !== 4'b1000) begin nErrors++; $display("[TB] FAIL over_hold got %b want 1000", {o_gameOver, o_respawn, o_lives}); end
    i_startGame = 1'b1; tick();
    nChecks++; if ({o_gameOver, o_respawn, o_lives, o_X_direction} !== 5'b01111) begin nErrors++; $display("[TB] FAIL restart got %b want 01111", {o_gameOver, o_respawn, o_lives, o_X_direction}); end
    i_startGame = 1'b0; tick();
  endtask

`ifdef SMILEY_CTRL_PAUSE_EN
  task automatic test_pause();
    i_jumpKey = 1'b1; tick(); i_jumpKey = 1'b0; tick();
    runFrames(2);
    i_pauseKey = 1'b1; tick(); i_pauseKey = 1'b0;
    i_startOfFrame = 1'b1; #1;
    nChecks++; if (o_frameTick !== 1'b0) begin nErrors++; $display("[TB] FAIL pause_no_tick got %0b want 0", o_frameTick); end
    tick(); i_startOfFrame = 1'b0; tick();
    runFrames(5);
    i_pauseKey = 1'b1; tick(); i_pauseKey = 1'b0;
    i_startOfFrame = 1'b1; #1;
    nChecks++; if (o_frameTick !== 1'b1) begin nErrors++; $display("[TB] FAIL resume_tick got %0b want 1", o_frameTick); end
    tick(); i_startOfFrame = 1'b0; tick();
    runFrames(4);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b0) begin nErrors++; $display("[TB] FAIL pause_cd_held got %0b want 0", o_toggleY); end
    i_jumpKey = 1'b0; tick();
    runFrames(1);
    i_jumpKey = 1'b1; tick();
    nChecks++; if (o_toggleY !== 1'b1) begin nErrors++; $display("[TB] FAIL pause_cd_expired got %0b want 1", o_toggleY); end
    i_jumpKey = 1'b0; tick();
  endtask
`endif

  task automatic test_reset_mid();
    i_dirKey = 1'b1; tick(); i_dirKey = 1'b0; tick();
    i_reset = 1'b1; #1;
    nChecks++; if ({o_lives, o_X_direction} !== 3'b001) begin nErrors++; $display("[TB] FAIL midreset_state got %b want 001", {o_lives, o_X_direction}); end
    tick(); i_reset = 1'b0; tick();
    i_startGame = 1'b1; tick();
    i_reset = 1'b1; #1;
    nChecks++; if (o_respawn !== 1'b0) begin nErrors++; $display("[TB] FAIL midreset_respawn got %0b want 0", o_respawn); end
    i_startGame = 1'b0; tick(); i_reset = 1'b0; tick();
    i_startGame = 1'b1; tick(); i_startGame = 1'b0; tick();
    i_jumpKey = 1'b1; tick();
    i_reset = 1'b1; #1;
    nChecks++; if (o_toggleY !== 1'b0) begin nErrors++; $display("[TB] FAIL midreset_toggle got %0b want 0", o_toggleY); end
    i_jumpKey = 1'b0; tick(); i_reset = 1'b0; tick();
  endtask

  initial begin
    $display("[TB] smiley_game_ctrl directed bench");
    test_reset();
    test_start();
    test_dir();
    test_jump();
    test_bonus_sat();
    test_hit();
    test_game_over();
`ifdef SMILEY_CTRL_PAUSE_EN
    test_pause();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
